onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width; byte lanes = DATA_W/8.
REQ-003 Parameter DEPTH, default 32000, number of implemented words.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 h_address/h_byteenable/h_read/h_write/h_writedata  in  ADDR_W/DATA_W/8/1/1/DATA_W  host requester command.
REQ-007 h_waitrequest/h_readdata/h_readdatavalid  out  1/DATA_W/1  host requester response.
REQ-008 s_address/s_byteenable/s_read/s_write/s_writedata  in  same widths  stream requester command.
REQ-009 s_waitrequest/s_readdata/s_readdatavalid  out  1/DATA_W/1  stream requester response.
REQ-010 mem_address/mem_byteenable/mem_writedata  out  ADDR_W/DATA_W/8/DATA_W  memory command.
REQ-011 mem_chipselect/mem_write/mem_clken  out  1/1/1  memory strobes; mem_clken held 1.
REQ-012 mem_readdata  in  DATA_W  memory read data, valid one cycle after the read is issued.

Function
REQ-013 At most one access SHALL be forwarded to memory per cycle; mem_* outputs SHALL be combinational from the granted requester.
REQ-014 A requester is pending when read or write is high; the granted pending requester SHALL see waitrequest=0, the other pending requester waitrequest=1.
REQ-015 A non-pending requester SHALL see waitrequest=0.
REQ-016 Arbiter state SHALL be one register last_grant in {HOST, STREAM}, updated to the granted requester on each issued access, otherwise held.
REQ-017 With both pending, the grant SHALL follow REQ-030/031; with one pending, that one SHALL be granted in the same cycle.
REQ-018 Read latency SHALL be exactly 1 cycle: a read issued in cycle N SHALL produce readdatavalid=1 for its owner in cycle N+1, readdata=mem_readdata.
REQ-019 Owner tag (rd_valid, rd_owner) SHALL be registered at issue; back-to-back reads from either or alternating requesters SHALL be sustained at one per cycle.
REQ-020 readdata outputs of the non-owner SHALL be 0; readdatavalid is never asserted for both requesters in one cycle.
REQ-021 Writes SHALL complete in the grant cycle (mem_chipselect=1, mem_write=1) with no response strobe.
REQ-022 read and write both high from one requester SHALL be treated as write; the read is discarded.
REQ-023 Address >= DEPTH: write SHALL be accepted with mem_chipselect=0; read SHALL be accepted, return readdata=0 with readdatavalid in N+1.
REQ-024 Write in cycle N followed by read of the same address in N+1 (either requester) SHALL return the new data.

Reset
REQ-025 While reset_n=0: all readdatavalid, readdata, mem_chipselect, mem_write = 0; waitrequest outputs = 0; last_grant=STREAM; rd_valid=0.
REQ-026 A read issued in the cycle reset asserts SHALL produce no readdatavalid.
REQ-027 Reset deassertion SHALL need no extra idle cycles; first contended grant after reset goes to HOST.

Configuration
REQ-028 Macro ONCHIP_MEM_ARB_RR_EN selects the contention policy.
REQ-029 Policy choice SHALL NOT change latency or any other requirement.
REQ-030 Defined: round-robin; on contention, grant the requester not equal to last_grant.
REQ-031 Undefined: fixed priority; HOST always wins contention; last_grant still maintained.

Structure
REQ-032 Shared package SHALL hold requester enum (HOST, STREAM), default ADDR_W/DATA_W/DEPTH constants.
REQ-033 One sub-module onchip_mem_arb_grant SHALL compute the grant from the two pending bits and last_grant; the rest stays in the top.

Verification
REQ-034 Host write 0xDEADBEEF to 0x0010 (byteenable 0xF), next cycle stream read 0x0010 -> s_readdatavalid one cycle later, s_readdata=0xDEADBEEF.
REQ-035 Both read continuously for 8 cycles, RR_EN defined -> grants alternate H,S,H,S..., 4 readdatavalid each, host first.
REQ-036 Same stimulus, RR_EN undefined -> host 8 grants, s_waitrequest=1 all 8 cycles.
REQ-037 Host write 0x12345678 to 32000, then read 32000 -> mem_chipselect=0 on write, h_readdata=0 with readdatavalid.
REQ-038 Byteenable 0x3 write 0xAAAA5555 over 0xFFFFFFFF, read back -> 0xFFFF5555.
REQ-039 reset_n low in the cycle a stream read issues -> no s_readdatavalid; after release, contended read grants HOST first.

Source files
------------

// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the on-chip memory arbiter: requester identity and
// default geometry of the shared memory.
package onchip_mem_arbiter_pkg;

  typedef enum logic {
    HOST   = 1'b0,
    STREAM = 1'b1
  } requester_t;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32000;

endpackage

// File: rtl/onchip_mem_arb_grant.sv
// Grant selection for the two-requester memory arbiter.
// Contention policy: ONCHIP_MEM_ARB_RR_EN defined -> round-robin against
// last_grant; undefined -> fixed priority, host wins.
module onchip_mem_arb_grant
  import onchip_mem_arbiter_pkg::*;
(
  input  logic       i_pend_h,
  input  logic       i_pend_s,
  input  requester_t i_last_grant,
  output logic       o_grant_vld,
  output requester_t o_grant
);

`ifndef ONCHIP_MEM_ARB_RR_EN
  // last_grant only matters for round-robin; kept on the port so both builds
  // share one interface.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  // Pick the winner among pending requesters; default to host when idle.
  always_comb begin
    o_grant_vld = i_pend_h | i_pend_s;
    o_grant     = HOST;
    if (i_pend_h && i_pend_s) begin
`ifdef ONCHIP_MEM_ARB_RR_EN
      o_grant = (i_last_grant == HOST) ? STREAM : HOST;
`else
      o_grant = HOST;
`endif
    end else if (i_pend_s) begin
      o_grant = STREAM;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter (host, stream) in front of a single-ported synchronous
// memory with one cycle of read latency. One access per cycle; commands to
// memory are combinational from the granted requester, read responses are
// routed back using an owner tag registered at issue.
// Build option: ONCHIP_MEM_ARB_RR_EN selects round-robin contention
// (default build is fixed priority with host winning).
module onchip_mem_arbiter
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  // host requester
  input  logic [ADDR_W-1:0]   h_address,
  input  logic [DATA_W/8-1:0] h_byteenable,
  input  logic                h_read,
  input  logic                h_write,
  input  logic [DATA_W-1:0]   h_writedata,
  output logic                h_waitrequest,
  output logic [DATA_W-1:0]   h_readdata,
  output logic                h_readdatavalid,
  // stream requester
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  // memory
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  // One extra bit so a DEPTH equal to 2**ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic                w_pend_h;
  logic                w_pend_s;
  logic                w_grant_vld;
  requester_t          w_grant;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W/8-1:0] w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wr;
  logic                w_rd;
  logic                w_in_range;

  requester_t r_last_grant;
  logic       r_rd_valid;
  requester_t r_rd_owner;
  logic       r_rd_oor;

  assign w_pend_h = h_read | h_write;
  assign w_pend_s = s_read | s_write;

  onchip_mem_arb_grant u_grant (
    .i_pend_h     (w_pend_h),
    .i_pend_s     (w_pend_s),
    .i_last_grant (r_last_grant),
    .o_grant_vld  (w_grant_vld),
    .o_grant      (w_grant)
  );

  // Nothing is issued while reset is held, even if requesters are active.
  assign w_issue = w_grant_vld & reset_n;

  // Command mux from the granted requester; write wins over a simultaneous read.
  always_comb begin
    w_addr  = h_address;
    w_be    = h_byteenable;
    w_wdata = h_writedata;
    w_wr    = h_write;
    w_rd    = h_read & ~h_write;
    if (w_grant == STREAM) begin
      w_addr  = s_address;
      w_be    = s_byteenable;
      w_wdata = s_writedata;
      w_wr    = s_write;
      w_rd    = s_read & ~s_write;
    end
  end

  assign w_in_range = ({1'b0, w_addr} < DEPTH_EXT);

  // Out-of-range accesses are accepted but never reach the memory.
  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wdata;
  assign mem_chipselect = w_issue & w_in_range;
  assign mem_write      = w_issue & w_in_range & w_wr;
  assign mem_clken      = 1'b1;

  assign h_waitrequest = reset_n & w_pend_h & (w_grant != HOST);
  assign s_waitrequest = reset_n & w_pend_s & (w_grant != STREAM);

  // Arbiter history and read-response tag, captured on each issued access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= STREAM;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= HOST;
      r_rd_oor     <= 1'b0;
    end else begin
      r_rd_valid <= w_issue & w_rd;
      if (w_issue) begin
        r_last_grant <= w_grant;
        r_rd_owner   <= w_grant;
        r_rd_oor     <= ~w_in_range;
      end
    end
  end

  // Route the read response to its owner; out-of-range reads return zero.
  always_comb begin
    h_readdatavalid = r_rd_valid & (r_rd_owner == HOST);
    s_readdatavalid = r_rd_valid & (r_rd_owner == STREAM);
    h_readdata      = '0;
    s_readdata      = '0;
    if (h_readdatavalid && !r_rd_oor) h_readdata = mem_readdata;
    if (s_readdatavalid && !r_rd_oor) s_readdata = mem_readdata;
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter with a behavioural
// synchronous memory (byte enables, one-cycle read latency).
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] h_address = '0;
  logic [3:0]        h_byteenable = '0;
  logic              h_read = 1'b0;
  logic              h_write = 1'b0;
  logic [DATA_W-1:0] h_writedata = '0;
  logic              h_waitrequest;
  logic [DATA_W-1:0] h_readdata;
  logic              h_readdatavalid;
  logic [ADDR_W-1:0] s_address = '0;
  logic [3:0]        s_byteenable = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [DATA_W-1:0] s_writedata = '0;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .h_address(h_address), .h_byteenable(h_byteenable), .h_read(h_read),
    .h_write(h_write), .h_writedata(h_writedata), .h_waitrequest(h_waitrequest),
    .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Behavioural memory
  logic [DATA_W-1:0] mem [0:32767];
  logic [DATA_W-1:0] r_q = '0;
  assign mem_readdata = r_q;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        r_q <= mem[mem_address];
      end
    end
  end

  task automatic set_h(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [3:0] be);
    h_read = rd; h_write = wr; h_address = a; h_writedata = d; h_byteenable = be;
  endtask

  task automatic set_s(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [3:0] be);
    s_read = rd; s_write = wr; s_address = a; s_writedata = d; s_byteenable = be;
  endtask

  task automatic idle();
    set_h(0, 0, '0, '0, '0);
    set_s(0, 0, '0, '0, '0);
  endtask

  // advance to just after the next active edge, where inputs are driven
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_h(1, 0, 15'h5, '0, 4'hF);
    set_s(0, 1, 15'h6, 32'hCAFE, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (h_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_h_wait got=%b exp=0", h_waitrequest); end
    checks++; if (s_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_s_wait got=%b exp=0", s_waitrequest); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_strobes got cs=%b wr=%b exp=0/0", mem_chipselect, mem_write); end
    checks++; if (h_readdatavalid !== 1'b0 || s_readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_valid got h=%b s=%b exp=0/0", h_readdatavalid, s_readdatavalid); end
    checks++; if (h_readdata !== '0 || s_readdata !== '0) begin failures++; $display("FAIL rst_rdata got h=%h s=%h exp=0", h_readdata, s_readdata); end
    checks++; if (mem_clken !== 1'b1) begin failures++; $display("FAIL rst_clken got=%b exp=1", mem_clken); end
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    step(); set_h(0, 1, 15'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin failures++; $display("FAIL wr_strobes got cs=%b wr=%b exp=1/1", mem_chipselect, mem_write); end
    checks++; if (h_waitrequest !== 1'b0 || mem_writedata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_cmd got wait=%b data=%h exp=0/deadbeef", h_waitrequest, mem_writedata); end
    step(); idle(); set_s(1, 0, 15'h10, '0, 4'hF);
    @(negedge clk);
    checks++; if (s_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 15'h10) begin failures++; $display("FAIL rd_cmd got wait=%b cs=%b wr=%b a=%h exp=0/1/0/0010", s_waitrequest, mem_chipselect, mem_write, mem_address); end
    checks++; if (s_readdatavalid !== 1'b0) begin failures++; $display("FAIL rd_early_valid got=%b exp=0", s_readdatavalid); end
    step(); idle();
    @(negedge clk);
    checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_resp got v=%b d=%h exp=1/deadbeef", s_readdatavalid, s_readdata); end
    checks++; if (h_readdatavalid !== 1'b0 || h_readdata !== '0) begin failures++; $display("FAIL rd_nonowner got v=%b d=%h exp=0/0", h_readdatavalid, h_readdata); end
  endtask

  task automatic test_back_to_back();
    step(); idle(); set_s(0, 1, 15'h11, 32'h01020304, 4'hF);
    step(); idle(); set_h(1, 0, 15'h10, '0, 4'hF);
    step(); idle(); set_s(1, 0, 15'h11, '0, 4'hF);
    @(negedge clk);
    checks++; if (h_readdatavalid !== 1'b1 || h_readdata !== 32'hDEADBEEF || s_readdatavalid !== 1'b0) begin failures++; $display("FAIL b2b_0 got hv=%b hd=%h sv=%b exp=1/deadbeef/0", h_readdatavalid, h_readdata, s_readdatavalid); end
    step(); idle(); set_h(1, 0, 15'h11, '0, 4'hF);
    @(negedge clk);
    checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'h01020304 || h_readdatavalid !== 1'b0) begin failures++; $display("FAIL b2b_1 got sv=%b sd=%h hv=%b exp=1/01020304/0", s_readdatavalid, s_readdata, h_readdatavalid); end
    step(); idle();
    @(negedge clk);
    checks++; if (h_readdatavalid !== 1'b1 || h_readdata !== 32'h01020304 || s_readdatavalid !== 1'b0) begin failures++; $display("FAIL b2b_2 got hv=%b hd=%h sv=%b exp=1/01020304/0", h_readdatavalid, h_readdata, s_readdatavalid); end
  endtask

  task automatic test_rw_both();
    step(); idle(); set_h(1, 1, 15'h40, 32'h00000055, 4'hF);
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin failures++; $display("FAIL rw_as_write got wr=%b cs=%b exp=1/1", mem_write, mem_chipselect); end
    step(); idle(); set_s(1, 0, 15'h40, '0, 4'hF);
    @(negedge clk);
    checks++; if (h_readdatavalid !== 1'b0) begin failures++; $display("FAIL rw_read_dropped got=%b exp=0", h_readdatavalid); end
    step(); idle();
    @(negedge clk);
    checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'h00000055) begin failures++; $display("FAIL wr_then_rd got v=%b d=%h exp=1/00000055", s_readdatavalid, s_readdata); end
  endtask

  task automatic test_byteenable();
    step(); idle(); set_h(0, 1, 15'h30, 32'hFFFFFFFF, 4'hF);
    step(); set_h(0, 1, 15'h30, 32'hAAAA5555, 4'h3);
    step(); set_h(1, 0, 15'h30, '0, 4'hF);
    step(); idle();
    @(negedge clk);
    checks++; if (h_readdatavalid !== 1'b1 || h_readdata !== 32'hFFFF5555) begin failures++; $display("FAIL byteen got v=%b d=%h exp=1/ffff5555", h_readdatavalid, h_readdata); end
  endtask

  task automatic test_out_of_range();
    step(); idle(); set_h(0, 1, 15'd32000, 32'h12345678, 4'hF);
    @(negedge clk);
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || h_waitrequest !== 1'b0) begin failures++; $display("FAIL oor_wr got cs=%b wr=%b wait=%b exp=0/0/0", mem_chipselect, mem_write, h_waitrequest); end
    step(); set_h(1, 0, 15'd32000, '0, 4'hF);
    @(negedge clk);
    checks++; if (h_waitrequest !== 1'b0) begin failures++; $display("FAIL oor_rd_wait got=%b exp=0", h_waitrequest); end
    step(); idle();
    @(negedge clk);
    checks++; if (h_readdatavalid !== 1'b1 || h_readdata !== '0) begin failures++; $display("FAIL oor_rd got v=%b d=%h exp=1/0", h_readdatavalid, h_readdata); end
  endtask

  task automatic test_contention();
    logic exp_h, prev_h;
    int n_h, n_s;
    n_h = 0; n_s = 0; prev_h = 1'b0;
    step(); idle(); set_h(0, 1, 15'h20, 32'h11111111, 4'hF);
    step(); idle(); set_s(0, 1, 15'h21, 32'h22222222, 4'hF);
    step(); set_h(1, 0, 15'h20, '0, 4'hF); set_s(1, 0, 15'h21, '0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
`ifdef ONCHIP_MEM_ARB_RR_EN
      exp_h = ((i % 2) == 0);
`else
      exp_h = 1'b1;
`endif
      @(negedge clk);
      checks++; if (h_waitrequest !== !exp_h || s_waitrequest !== exp_h) begin failures++; $display("FAIL cont_wait%0d got h=%b s=%b exp h=%b s=%b", i, h_waitrequest, s_waitrequest, !exp_h, exp_h); end
      checks++; if (mem_address !== (exp_h ? 15'h20 : 15'h21)) begin failures++; $display("FAIL cont_addr%0d got=%h exp=%h", i, mem_address, exp_h ? 15'h20 : 15'h21); end
      if (h_readdatavalid) n_h++;
      if (s_readdatavalid) n_s++;
      if (i > 0) begin
        checks++; if (h_readdatavalid !== prev_h || s_readdatavalid !== !prev_h) begin failures++; $display("FAIL cont_valid%0d got h=%b s=%b exp h=%b s=%b", i, h_readdatavalid, s_readdatavalid, prev_h, !prev_h); end
        checks++; if ((prev_h ? h_readdata : s_readdata) !== (prev_h ? 32'h11111111 : 32'h22222222)) begin failures++; $display("FAIL cont_data%0d got h=%h s=%h", i, h_readdata, s_readdata); end
      end
      prev_h = exp_h;
    end
    step(); idle();
    @(negedge clk);
    if (h_readdatavalid) n_h++;
    if (s_readdatavalid) n_s++;
`ifdef ONCHIP_MEM_ARB_RR_EN
    checks++; if (n_h !== 4 || n_s !== 4) begin failures++; $display("FAIL cont_counts got h=%0d s=%0d exp=4/4", n_h, n_s); end
`else
    checks++; if (n_h !== 8 || n_s !== 0) begin failures++; $display("FAIL cont_counts got h=%0d s=%0d exp=8/0", n_h, n_s); end
`endif
  endtask

  task automatic test_reset_midread();
    step(); idle(); set_s(1, 0, 15'h10, '0, 4'hF);
    #2 reset_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_chipselect !== 1'b0 || s_waitrequest !== 1'b0) begin failures++; $display("FAIL midrst_cmd got cs=%b wait=%b exp=0/0", mem_chipselect, s_waitrequest); end
    step(); reset_n = 1'b1;
    set_h(1, 0, 15'h20, '0, 4'hF); set_s(1, 0, 15'h21, '0, 4'hF);
    @(negedge clk);
    checks++; if (s_readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", s_readdatavalid); end
    checks++; if (h_waitrequest !== 1'b0 || s_waitrequest !== 1'b1 || mem_address !== 15'h20) begin failures++; $display("FAIL postrst_grant got hw=%b sw=%b a=%h exp=0/1/0020", h_waitrequest, s_waitrequest, mem_address); end
    step(); idle();
    @(negedge clk);
    checks++; if (h_readdatavalid !== 1'b1 || h_readdata !== 32'h11111111 || s_readdatavalid !== 1'b0) begin failures++; $display("FAIL postrst_resp got hv=%b hd=%h sv=%b exp=1/11111111/0", h_readdatavalid, h_readdata, s_readdatavalid); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rw_both();
    test_byteenable();
    test_out_of_range();
    test_contention();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
